shift_pipe: RTL and testbench
=============================

// Module: shift_pipe
// PURPOSE
//   Parametrised, pipelined barrel shifter with valid/ready handshake for the Mul32U datapath
//   and the wider ALU work that follows it. Supports SLL/SRL/SRA, with ROL as a compile option.
//   Built as log2(WIDTH) mux levels, with a register after every LVL_PER_STAGE levels.
//   Full throughput (1 beat/cycle); each stage absorbs back-pressure.
// PARAMETERS
//   WIDTH          64  data width; power of 2, 8..128
//   LVL_PER_STAGE  2   mux levels per pipeline stage, 1..log2(WIDTH)
//   (local) NL = $clog2(WIDTH); LATENCY = ceil(NL/LVL_PER_STAGE) (=3 at defaults)
// PORTS
//   clk        in   1      clock, rising edge
//   rst_n      in   1      asynchronous reset, active low
//   in_valid   in   1      input beat valid
//   in_ready   out  1      input beat accepted when in_valid & in_ready
//   in_op      in   2      00 SLL, 01 SRL, 10 SRA, 11 ROL (see CONFIGURATION)
//   in_amt     in   8      shift amount, unsigned
//   in_data    in   WIDTH  operand
//   out_valid  out  1      result valid
//   out_ready  in   1      downstream accepts when out_valid & out_ready
//   out_data   out  WIDTH  result
// BEHAVIOUR
// - Reset: all stage valid bits 0, out_valid=0, out_data=0; in_ready=0 while rst_n low.
//   Asynchronous reset; in-flight beats are dropped with no partial output.
// - Stage k holds: valid, data, op, residual amount bits, and an ovf flag.
//   Ready chain: rdy[LAST]=out_ready; rdy[k] = !v[k] | rdy[k+1]; in_ready = rdy[0] (combinational).
//   A stage may load a new beat and hand its old beat on in the same cycle.
//   A stage that is stalled (v & !rdy) holds its contents stable.
// - Latency: accepted at edge t, out_valid at t+LATENCY if no stall; order preserved.
//   No beat is lost or duplicated.
// - Amount rule, decided at entry to stage 0:
//   SLL/SRL: amt >= WIDTH -> ovf=1 -> result 0.
//   SRA:     amt >= WIDTH -> result = all copies of in_data[WIDTH-1].
//   ROL:     amt taken modulo WIDTH (low NL bits); ovf is never set.
// - Level j (0..NL-1) shifts by 2^j when amt[j]=1.
//   Fill is 0 for SLL/SRL, the sign bit for SRA, and wrapped bits for ROL.
// - amt=0 -> out_data=in_data for every op.
// - Sign bit for SRA is the operand MSB captured at acceptance, carried with the beat.
// - out_data updates only when the last stage loads; holds while out_valid & !out_ready.
// - No combinational path from in_data/in_amt/in_op to out_data.
// CONFIGURATION
//   `SHIFT_ROTATE_EN defined: op 11 = rotate left, amt mod WIDTH.
//   `SHIFT_ROTATE_EN undefined: op 11 decodes exactly as SLL (incl. amt>=WIDTH -> 0).
//     Rotate wrap muxes are not built.
// TESTING (WIDTH=64, LVL_PER_STAGE=2, LATENCY=3, out_ready=1 unless noted)
// - SLL in=0x1 amt=63 -> out=0x8000_0000_0000_0000 exactly 3 cycles after accept.
// - SRA in=0x8000_0000_0000_0000 amt=4 -> 0xF800_0000_0000_0000;
//   same in, amt=200 -> 0xFFFF_FFFF_FFFF_FFFF.
// - SRL in=0xFFFF_FFFF_FFFF_FFFF, amt=64 -> 0 and amt=0 -> unchanged;
//   back-to-back beats -> 1 result per cycle.
// - Back-pressure: stream 6 beats amt=1..6 with out_ready=0 for 5 cycles ->
//   in_ready=0 once 3 beats are held, out_data stable.
//   Release -> all 6 results in order, none lost or duplicated.
// - ROL with macro: in=0x8000_0000_0000_0001 amt=68 -> 0x0000_0000_0000_0018;
//   without macro, op=11 amt=4 -> 0x0000_0000_0000_0010.
// - Reset mid-stream: 3 beats in flight, pull rst_n low mid-cycle ->
//   out_valid=0 and out_data=0 immediately; no stale beat after release; in_ready=1 next cycle.

Source files
------------

// File: rtl/shift_pipe.sv
// Pipelined barrel shifter with valid/ready handshake.
// Ops: 00 SLL, 01 SRL, 10 SRA, 11 ROL when SHIFT_ROTATE_EN is defined (otherwise 11 = SLL).
// log2(WIDTH) mux levels, registered after every LVL_PER_STAGE levels.
module shift_pipe #(
  parameter int unsigned WIDTH         = 64,
  parameter int unsigned LVL_PER_STAGE = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [7:0]       in_amt,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  localparam int unsigned NL      = $clog2(WIDTH);
  localparam int unsigned LATENCY = (NL + LVL_PER_STAGE - 1) / LVL_PER_STAGE;

  localparam logic [1:0] OpSll = 2'b00;
  localparam logic [1:0] OpSrl = 2'b01;
  localparam logic [1:0] OpSra = 2'b10;
  localparam logic [1:0] OpRol = 2'b11;

  // One mux level: shift by 2^j with the op-specific fill.
  function automatic logic [WIDTH-1:0] shift_level(input logic [WIDTH-1:0] d,
                                                   input logic [1:0]       op,
                                                   input logic             sgn,
                                                   input int unsigned      j);
    logic [WIDTH-1:0] r;
    int unsigned      sh;
    sh = 32'd1 << j;
    case (op)
      OpSrl:   r = d >> sh;
      OpSra:   r = (d >> sh) | (sgn ? ~({WIDTH{1'b1}} >> sh) : '0);
`ifdef SHIFT_ROTATE_EN
      OpRol:   r = (d << sh) | (d >> (WIDTH - sh));
`endif
      default: r = d << sh;
    endcase
    return r;
  endfunction

  // Stage interface: index 0 is the entry, index k+1 is the output of stage k.
  logic             s_v    [LATENCY+1];
  logic [WIDTH-1:0] s_data [LATENCY+1];
  logic [1:0]       s_op   [LATENCY];
  logic [NL-1:0]    s_amt  [LATENCY];
  logic             s_ovf  [LATENCY];
  logic             s_sign [LATENCY];
  logic [LATENCY:0] rdy;

  logic [1:0]       entry_op;
  logic             entry_ovf;
  logic [WIDTH-1:0] entry_data;

  // Entry decode: op normalisation and the out-of-range amount rule.
  always_comb begin
    entry_op = in_op;
`ifndef SHIFT_ROTATE_EN
    if (in_op == OpRol) entry_op = OpSll;
`endif
    entry_ovf = (32'(in_amt) >= WIDTH);
`ifdef SHIFT_ROTATE_EN
    if (entry_op == OpRol) entry_ovf = 1'b0;
`endif
    entry_data = in_data;
    // Overflowed beats are resolved here; the levels then leave them untouched.
    if (entry_ovf) entry_data = (entry_op == OpSra && in_data[WIDTH-1]) ? '1 : '0;
  end

  assign s_v[0]    = in_valid;
  assign s_data[0] = entry_data;
  assign s_op[0]   = entry_op;
  assign s_amt[0]  = in_amt[NL-1:0];
  assign s_ovf[0]  = entry_ovf;
  assign s_sign[0] = in_data[WIDTH-1];

  // Ready chain from the output back to the input.
  always_comb begin
    rdy[LATENCY] = out_ready;
    for (int k = LATENCY - 1; k >= 0; k--) begin
      rdy[k] = !s_v[k+1] | rdy[k+1];
    end
  end

  assign in_ready = rdy[0] & rst_n;

  for (genvar k = 0; k < LATENCY; k++) begin : g_stage
    localparam int unsigned Lo = k * LVL_PER_STAGE;
    localparam int unsigned Hi = (Lo + LVL_PER_STAGE > NL) ? NL : Lo + LVL_PER_STAGE;

    logic [WIDTH-1:0] data_d;
    logic [WIDTH-1:0] data_q;
    logic             v_q;
    logic             load;

    assign load = rdy[k] & s_v[k];

    // Apply this stage's mux levels to the incoming beat.
    always_comb begin
      data_d = s_data[k];
      for (int unsigned j = Lo; j < Hi; j++) begin
        if (s_amt[k][j] && !s_ovf[k]) data_d = shift_level(data_d, s_op[k], s_sign[k], j);
      end
    end

    // Valid/data register; holds while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q    <= 1'b0;
        data_q <= '0;
      end else begin
        if (rdy[k]) v_q <= s_v[k];
        if (load)   data_q <= data_d;
      end
    end

    assign s_v[k+1]    = v_q;
    assign s_data[k+1] = data_q;

    // Side-band (op, amount, ovf, sign) only needed by later stages.
    if (k < LATENCY - 1) begin : g_side
      logic [1:0]    op_q;
      logic [NL-1:0] amt_q;
      logic          ovf_q;
      logic          sign_q;

      // Carry the beat's control fields alongside its data.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          op_q   <= '0;
          amt_q  <= '0;
          ovf_q  <= 1'b0;
          sign_q <= 1'b0;
        end else if (load) begin
          op_q   <= s_op[k];
          amt_q  <= s_amt[k];
          ovf_q  <= s_ovf[k];
          sign_q <= s_sign[k];
        end
      end

      assign s_op[k+1]   = op_q;
      assign s_amt[k+1]  = amt_q;
      assign s_ovf[k+1]  = ovf_q;
      assign s_sign[k+1] = sign_q;
    end
  end

  assign out_valid = s_v[LATENCY];
  assign out_data  = s_data[LATENCY];

endmodule

// File: tb/tb_shift_pipe.sv
// Self-checking bench for shift_pipe (WIDTH=64, LVL_PER_STAGE=2).
module tb_shift_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  in_op = 2'b00;
  logic [7:0]  in_amt = 8'd0;
  logic [63:0] in_data = 64'd0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] out_data;

  shift_pipe #(.WIDTH(64), .LVL_PER_STAGE(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_amt    (in_amt),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] res;
    int          acc;
    bit          lat;
  } exp_t;

  exp_t        q[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          fires = 0;
  int          first_fire = 0;
  int          last_fire = 0;
  bit          acc_last = 0;
  bit          rdy_last = 0;
  bit          lat_flag = 0;
  bit          hold_chk = 0;
  logic [63:0] hold_data = 64'd0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: shift rules applied directly with wide arithmetic.
  function automatic logic [63:0] model(input logic [1:0] op, input logic [7:0] amt,
                                        input logic [63:0] d);
    int           a;
    logic [127:0] dbl;
    a = int'(amt);
`ifdef SHIFT_ROTATE_EN
    if (op == 2'b11) begin
      dbl = {d, d} << (a % 64);
      return dbl[127:64];
    end
`endif
    if (op == 2'b11) op = 2'b00;
    case (op)
      2'b00:   return (a >= 64) ? 64'd0 : d << a;
      2'b01:   return (a >= 64) ? 64'd0 : d >> a;
      default: return (a >= 64) ? {64{d[63]}} : 64'($signed(d) >>> a);
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // One clock: sample just after the falling edge, score the handshakes, advance.
  task automatic tick();
    exp_t e;
    int   cur;
    #1;
    cur = cyc;
    rdy_last = in_ready;
    acc_last = in_valid && in_ready;
    if (hold_chk) begin
      chk("hold_valid", 64'(out_valid), 64'd1);
      chk("hold_data", out_data, hold_data);
    end
    hold_chk  = out_valid && !out_ready;
    hold_data = out_data;
    if (out_valid && out_ready) begin
      if (q.size() == 0) begin
        chk("unexpected_out", 64'(q.size()), 64'd1);
      end else begin
        e = q.pop_front();
        chk("data", out_data, e.res);
        if (e.lat) chk("latency", 64'(cur - e.acc), 64'd3);
      end
      if (fires == 0) first_fire = cur;
      last_fire = cur;
      fires++;
    end
    if (acc_last) q.push_back('{res: model(in_op, in_amt, in_data), acc: cur, lat: lat_flag});
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send(input logic [1:0] op, input logic [7:0] amt, input logic [63:0] d,
                      input bit lat);
    int n;
    in_valid = 1'b1;
    in_op    = op;
    in_amt   = amt;
    in_data  = d;
    lat_flag = lat;
    n = 0;
    do begin
      tick();
      n++;
    end while (!acc_last && n < 50);
    if (!acc_last) chk("accept_timeout", 64'(n), 64'd0);
    in_valid = 1'b0;
    lat_flag = 0;
  endtask

  task automatic drain();
    int n;
    in_valid = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while (q.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    chk("drain_empty", 64'(q.size()), 64'd0);
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed corner cases
    send(2'b00, 8'd63, 64'h1, 1'b1);
    send(2'b10, 8'd4, 64'h8000_0000_0000_0000, 1'b0);
    send(2'b10, 8'd200, 64'h8000_0000_0000_0000, 1'b0);
    send(2'b01, 8'd64, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    send(2'b01, 8'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    send(2'b11, 8'd4, 64'h1, 1'b0);
    send(2'b11, 8'd68, 64'h8000_0000_0000_0001, 1'b0);
    send(2'b10, 8'd0, 64'h8123_4567_89AB_CDEF, 1'b0);
    send(2'b10, 8'd63, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0);
    drain();

    // Back-to-back throughput
    fires = 0;
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_op   = 2'($urandom);
      in_amt  = 8'($urandom_range(0, 70));
      in_data = {$urandom, $urandom};
      tick();
      chk("b2b_accept", 64'(acc_last), 64'd1);
    end
    drain();
    chk("b2b_count", 64'(fires), 64'd8);
    chk("b2b_span", 64'(last_fire - first_fire), 64'd7);

    // Back-pressure: downstream stalled for 5 cycles
    begin
      int accepted;
      accepted = 0;
      fires = 0;
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
        in_valid = 1'b1;
        in_op    = 2'b00;
        in_amt   = 8'(accepted + 1);
        in_data  = 64'hA5A5_0000_0000_F00D + 64'(accepted);
        tick();
        if (i >= 3) chk("bp_in_ready", 64'(rdy_last), 64'd0);
        if (acc_last) accepted++;
      end
      chk("bp_held", 64'(accepted), 64'd3);
      out_ready = 1'b1;
      for (int b = accepted; b < 6; b++) begin
        send(2'b00, 8'(b + 1), 64'hA5A5_0000_0000_F00D + 64'(b), 1'b0);
      end
      drain();
      chk("bp_count", 64'(fires), 64'd6);
    end

    // Random traffic with random back-pressure
    for (int i = 0; i < 300; i++) begin
      in_valid  = ($urandom % 4) != 0;
      out_ready = ($urandom % 4) != 0;
      in_op     = 2'($urandom);
      in_amt    = (($urandom % 4) == 0) ? 8'($urandom) : 8'($urandom_range(0, 70));
      in_data   = {$urandom, $urandom};
      tick();
    end
    drain();

    // Reset with beats in flight
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_op   = 2'b01;
      in_amt  = 8'(i);
      in_data = {$urandom, $urandom} | 64'h1;
      tick();
    end
    in_valid = 1'b0;
    chk("pre_rst_valid", 64'(out_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_out_data", out_data, 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd0);
    q.delete();
    hold_chk = 0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);
    fires = 0;
    for (int i = 0; i < 6; i++) tick();
    chk("no_stale", 64'(fires), 64'd0);
    send(2'b10, 8'd8, 64'h8000_0000_0000_0000, 1'b1);
    drain();
    chk("post_rst_count", 64'(fires), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
